// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared types and constants for the UART command framer.
//               Holds the RX/TX state enums, the command and byte widths,
//               and the default inter-byte timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  localparam int CMD_W  = 24;
  localparam int BYTE_W = 8;

  // ~50 ms at 50 MHz; only meaningful when UART_CMD_TIMEOUT_EN is defined
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 32'd2_604_166;
  localparam int          DEFAULT_TO_W        = 22;

  typedef enum logic [1:0] {
    BYTE_HI  = 2'd0,
    BYTE_MID = 2'd1,
    BYTE_LO  = 2'd2
  } rx_state_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XMIT = 1'b1
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_proc_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_proc_if
// Description : Bundles the UART byte handshake, the command/consumer
//               handshake and the response/transmitter handshake.
//   master : the command processor (drives clr_rdy, cmd*, frame_err,
//            trmt, tx_data, resp_busy)
//   slave  : the surrounding UART + control logic (drives the rest)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_proc_if;
  import uart_cmd_pkg::*;

  logic              rdy;
  logic [BYTE_W-1:0] rx_data;
  logic              clr_rdy;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic              cmd_ovr;
  logic              frame_err;
  logic              send_resp;
  logic [BYTE_W-1:0] resp;
  logic              trmt;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_done;
  logic              resp_busy;

  modport master (
    input  rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
    output clr_rdy, cmd, cmd_rdy, cmd_ovr, frame_err, trmt, tx_data, resp_busy
  );

  modport slave (
    output rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
    input  clr_rdy, cmd, cmd_rdy, cmd_ovr, frame_err, trmt, tx_data, resp_busy
  );

endinterface
`default_nettype wire

// File: rtl/uart_resp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_resp_ctrl
// Description : Response transmit controller. Accepts one response byte per
//               request, pulses trmt for one cycle with tx_data valid, and
//               stays busy until the transmitter's tx_done rises.
// Ports       : clk, rst_n (async, active low)
//               send_resp/resp   - request and byte (in)
//               tx_done          - transmitter completion level (in)
//               trmt/tx_data     - start pulse and held byte (out)
//               resp_busy        - request in flight (out)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_resp_ctrl
  import uart_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send_resp,
  input  logic [BYTE_W-1:0] resp,
  input  logic              tx_done,
  output logic              trmt,
  output logic [BYTE_W-1:0] tx_data,
  output logic              resp_busy
);

  tx_state_t         state_q, state_d;
  logic              trmt_q, trmt_d;
  logic              resp_busy_q, resp_busy_d;
  logic              tx_done_prev_q, tx_done_prev_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_done_rise;

  // A level already high at request time is not a completion; only a rise is
  assign tx_done_rise = tx_done && !tx_done_prev_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      trmt_q         <= 1'b0;
      resp_busy_q    <= 1'b0;
      tx_done_prev_q <= 1'b0;
      tx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      trmt_q         <= trmt_d;
      resp_busy_q    <= resp_busy_d;
      tx_done_prev_q <= tx_done_prev_d;
      tx_data_q      <= tx_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (send_resp) state_d = XMIT;
      XMIT:    if (tx_done_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; requests seen in XMIT are dropped, not queued
  always_comb begin
    trmt_d         = 1'b0;
    resp_busy_d    = resp_busy_q;
    tx_data_d      = tx_data_q;
    tx_done_prev_d = tx_done;
    case (state_q)
      IDLE: begin
        if (send_resp) begin
          tx_data_d   = resp;
          trmt_d      = 1'b1;
          resp_busy_d = 1'b1;
        end
      end
      XMIT: begin
        if (tx_done_rise) resp_busy_d = 1'b0;
      end
      default: resp_busy_d = 1'b0;
    endcase
  end

  assign trmt      = trmt_q;
  assign tx_data   = tx_data_q;
  assign resp_busy = resp_busy_q;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_proc.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_proc
// Description : UART command framer. Assembles opcode, data-high and
//               data-low bytes into a 24-bit command with sticky ready and
//               overrun flags, and returns one response byte per request
//               through uart_resp_ctrl.
// Ports       : clk, rst_n (async, active low)
//               bus (uart_cmd_proc_if.master) - rx handshake, command
//               handshake, response/transmit handshake
// Config      : UART_CMD_TIMEOUT_EN - when defined, an idle counter aborts a
//               partial command after TIMEOUT_CYC cycles and pulses
//               frame_err; otherwise frame_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_proc
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int          TO_W        = DEFAULT_TO_W
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_cmd_proc_if.master bus
);

  rx_state_t         state_q, state_d;
  logic [BYTE_W-1:0] op_q, op_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              cmd_ovr_q, cmd_ovr_d;
  logic              clr_rdy_q, clr_rdy_d;
  logic              capture;
  logic              timeout;

  // rdy is still high in the cycle clr_rdy is asserted; gate it out
  assign capture = bus.rdy && !clr_rdy_q;

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            frame_err_q, frame_err_d;

  // A capture in the expiry cycle takes priority over the timeout
  assign timeout = (state_q != BYTE_HI) && !capture && (to_cnt_q == TO_LAST);

  always_comb begin
    to_cnt_d    = '0;
    frame_err_d = timeout;
    if ((state_q != BYTE_HI) && !capture && !timeout)
      to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.frame_err = frame_err_q;
`else
  assign timeout       = 1'b0;
  assign bus.frame_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BYTE_HI;
      op_q      <= '0;
      hi_q      <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      cmd_ovr_q <= 1'b0;
      clr_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      cmd_ovr_q <= cmd_ovr_d;
      clr_rdy_q <= clr_rdy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BYTE_HI:  if (capture) state_d = BYTE_MID;
      BYTE_MID: if (capture) state_d = BYTE_LO; else if (timeout) state_d = BYTE_HI;
      BYTE_LO:  if (capture || timeout) state_d = BYTE_HI;
      default:  state_d = BYTE_HI;
    endcase
  end

  // Output/datapath logic. The first two bytes sit in shadow registers so
  // cmd only ever changes as a whole on the third capture.
  always_comb begin
    op_d      = op_q;
    hi_d      = hi_q;
    cmd_d     = cmd_q;
    clr_rdy_d = capture;
    cmd_rdy_d = cmd_rdy_q && !bus.clr_cmd_rdy;
    cmd_ovr_d = cmd_ovr_q && !bus.clr_cmd_rdy;
    if (capture) begin
      case (state_q)
        BYTE_HI:  op_d = bus.rx_data;
        BYTE_MID: hi_d = bus.rx_data;
        BYTE_LO: begin
          cmd_d     = {op_q, hi_q, bus.rx_data};
          cmd_rdy_d = 1'b1;
          // A coincident acknowledge consumed the old command: no overrun
          cmd_ovr_d = (cmd_ovr_q || cmd_rdy_q) && !bus.clr_cmd_rdy;
        end
        default: ;
      endcase
    end
  end

  assign bus.clr_rdy = clr_rdy_q;
  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.cmd_ovr = cmd_ovr_q;

  uart_resp_ctrl u_resp_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .send_resp (bus.send_resp),
    .resp      (bus.resp),
    .tx_done   (bus.tx_done),
    .trmt      (bus.trmt),
    .tx_data   (bus.tx_data),
    .resp_busy (bus.resp_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_proc.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_proc
// Description : Self-checking bench for uart_cmd_proc. Directed scenarios
//               plus a randomized command/response run checked against a
//               byte-grouping reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_cmd_proc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_cmd_proc_if bus();

  uart_cmd_proc #(.TIMEOUT_CYC(100), .TO_W(22)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int clr_cnt = 0;
  int trmt_cnt = 0;
  int ferr_cnt = 0;

  // Counts cycles each pulse output was high (value held since last edge)
  always @(posedge clk) begin
    if (bus.clr_rdy === 1'b1)   clr_cnt++;
    if (bus.trmt === 1'b1)      trmt_cnt++;
    if (bus.frame_err === 1'b1) ferr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a byte, holds rdy until clr_rdy, then drops it. clr_with puts
  // clr_cmd_rdy in the capture cycle; send_resp (if set by the caller) is
  // also released after that cycle.
  task automatic send_byte(input logic [7:0] b, input bit clr_with);
    int k;
    bus.rx_data = b;
    bus.rdy = 1'b1;
    if (clr_with) bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    k = 0;
    while (bus.clr_rdy !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (bus.clr_rdy !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL byte_ack: clr_rdy=%b required 1 within 20 cycles", bus.clr_rdy);
    end
    bus.rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic pulse_clr_cmd();
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    n_tests++;
    if ({bus.clr_rdy, bus.cmd, bus.cmd_rdy, bus.cmd_ovr, bus.frame_err, bus.trmt, bus.tx_data, bus.resp_busy} !== 39'h0) begin
      n_fail++; $display("FAIL reset_hold: outputs=%h required 0", {bus.clr_rdy, bus.cmd, bus.cmd_rdy, bus.cmd_ovr, bus.frame_err, bus.trmt, bus.tx_data, bus.resp_busy});
    end
    rst_n = 1'b1;
    tick(2);
    n_tests++;
    if ({bus.clr_rdy, bus.cmd, bus.cmd_rdy, bus.cmd_ovr, bus.frame_err, bus.trmt, bus.tx_data, bus.resp_busy} !== 39'h0) begin
      n_fail++; $display("FAIL reset_release: outputs=%h required 0", {bus.clr_rdy, bus.cmd, bus.cmd_rdy, bus.cmd_ovr, bus.frame_err, bus.trmt, bus.tx_data, bus.resp_busy});
    end
  endtask

  task automatic test_basic_cmd();
    int c0;
    c0 = clr_cnt;
    send_cmd(8'hA5, 8'h12, 8'h34);
    tick(2);
    n_tests++; if (bus.cmd !== 24'hA51234) begin n_fail++; $display("FAIL basic_cmd: got %h required a51234", bus.cmd); end
    n_tests++; if (bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_rdy: got %b required 1", bus.cmd_rdy); end
    n_tests++; if (bus.cmd_ovr !== 1'b0) begin n_fail++; $display("FAIL basic_ovr: got %b required 0", bus.cmd_ovr); end
    n_tests++; if (clr_cnt - c0 !== 3) begin n_fail++; $display("FAIL basic_clr_pulses: got %0d required 3", clr_cnt - c0); end
  endtask

  task automatic test_overrun();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    n_tests++; if (bus.cmd !== 24'hA51234) begin n_fail++; $display("FAIL partial_visible: got %h required a51234", bus.cmd); end
    send_byte(8'h02, 1'b0);
    n_tests++; if (bus.cmd !== 24'h010002) begin n_fail++; $display("FAIL ovr_cmd: got %h required 010002", bus.cmd); end
    n_tests++; if (bus.cmd_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b required 1", bus.cmd_ovr); end
    pulse_clr_cmd();
    n_tests++; if ({bus.cmd_rdy, bus.cmd_ovr} !== 2'b00) begin n_fail++; $display("FAIL ovr_clear: rdy,ovr=%b required 00", {bus.cmd_rdy, bus.cmd_ovr}); end
  endtask

  task automatic test_resp();
    int t0;
    t0 = trmt_cnt;
    bus.resp = 8'hC3; bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    n_tests++; if ({bus.trmt, bus.tx_data, bus.resp_busy} !== {1'b1, 8'hC3, 1'b1}) begin n_fail++; $display("FAIL resp_start: trmt,tx_data,busy=%b,%h,%b required 1,c3,1", bus.trmt, bus.tx_data, bus.resp_busy); end
    bus.resp = 8'h5A; bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    n_tests++; if ({bus.trmt, bus.tx_data, bus.resp_busy} !== {1'b0, 8'hC3, 1'b1}) begin n_fail++; $display("FAIL resp_busy_drop: trmt,tx_data,busy=%b,%h,%b required 0,c3,1", bus.trmt, bus.tx_data, bus.resp_busy); end
    tick(3);
    bus.tx_done = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.resp_busy !== 1'b0) begin n_fail++; $display("FAIL resp_done: busy=%b required 0", bus.resp_busy); end
    bus.tx_done = 1'b0;
    tick(2);
    n_tests++; if (trmt_cnt - t0 !== 1) begin n_fail++; $display("FAIL resp_trmt_count: got %0d required 1", trmt_cnt - t0); end
  endtask

  task automatic test_timeout();
    int f0, k;
    logic [23:0] prev;
    prev = bus.cmd;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    f0 = ferr_cnt;
`ifdef UART_CMD_TIMEOUT_EN
    k = 0;
    while (bus.frame_err !== 1'b1 && k < 150) begin @(negedge clk); k++; end
    n_tests++; if (bus.frame_err !== 1'b1 || k < 90 || k > 110) begin n_fail++; $display("FAIL timeout_pulse: frame_err=%b after %0d cycles required 1 near 100", bus.frame_err, k); end
    @(negedge clk);
    n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL timeout_width: frame_err=%b required 0", bus.frame_err); end
    n_tests++; if (bus.cmd !== prev) begin n_fail++; $display("FAIL timeout_cmd_kept: got %h required %h", bus.cmd, prev); end
    send_cmd(8'h33, 8'h44, 8'h55);
    n_tests++; if (bus.cmd !== 24'h334455) begin n_fail++; $display("FAIL timeout_recover: got %h required 334455", bus.cmd); end
`else
    tick(150);
    n_tests++; if (ferr_cnt - f0 !== 0 || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL no_timeout: frame_err pulses=%0d required 0", ferr_cnt - f0); end
    n_tests++; if (bus.cmd !== prev) begin n_fail++; $display("FAIL no_timeout_cmd: got %h required %h", bus.cmd, prev); end
    send_byte(8'h33, 1'b0);
    n_tests++; if (bus.cmd !== 24'h112233) begin n_fail++; $display("FAIL no_timeout_wait: got %h required 112233", bus.cmd); end
    k = 0;
`endif
    pulse_clr_cmd();
  endtask

  task automatic test_reset_mid();
    send_byte(8'hEE, 1'b0);
    send_byte(8'hFF, 1'b0);
    bus.resp = 8'h77; bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.clr_rdy, bus.cmd, bus.cmd_rdy, bus.cmd_ovr, bus.frame_err, bus.trmt, bus.tx_data, bus.resp_busy} !== 39'h0) begin
      n_fail++; $display("FAIL reset_mid: outputs=%h required 0", {bus.clr_rdy, bus.cmd, bus.cmd_rdy, bus.cmd_ovr, bus.frame_err, bus.trmt, bus.tx_data, bus.resp_busy});
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    send_cmd(8'h0A, 8'h0B, 8'h0C);
    n_tests++; if ({bus.cmd, bus.cmd_rdy, bus.cmd_ovr} !== {24'h0A0B0C, 1'b1, 1'b0}) begin n_fail++; $display("FAIL reset_recover: cmd,rdy,ovr=%h,%b,%b required 0a0b0c,1,0", bus.cmd, bus.cmd_rdy, bus.cmd_ovr); end
  endtask

  task automatic test_coincident_clr();
    send_cmd(8'h04, 8'h05, 8'h06);
    n_tests++; if (bus.cmd_ovr !== 1'b1) begin n_fail++; $display("FAIL coinc_pre_ovr: got %b required 1", bus.cmd_ovr); end
    send_byte(8'h07, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h09, 1'b1);
    n_tests++; if ({bus.cmd, bus.cmd_rdy, bus.cmd_ovr} !== {24'h070809, 1'b1, 1'b0}) begin n_fail++; $display("FAIL coinc_clr: cmd,rdy,ovr=%h,%b,%b required 070809,1,0", bus.cmd, bus.cmd_rdy, bus.cmd_ovr); end
  endtask

  // Random commands and overlapping response requests against a model that
  // groups bytes in threes and tracks the consumer flags abstractly.
  task automatic test_random();
    bit          exp_rdy, exp_ovr, do_resp, coinc, hold2;
    logic [7:0]  b[3];
    logic [7:0]  r;
    logic [23:0] exp_cmd;
    int          c0, t0;
    pulse_clr_cmd();
    exp_rdy = 1'b0; exp_ovr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 3; j++) b[j] = 8'($urandom);
      r       = 8'($urandom);
      exp_cmd = {b[0], b[1], b[2]};
      do_resp = 1'($urandom_range(0, 1));
      coinc   = ($urandom_range(0, 3) == 0);
      hold2   = 1'($urandom_range(0, 1));
      c0 = clr_cnt; t0 = trmt_cnt;
      if (do_resp) begin bus.resp = r; bus.send_resp = 1'b1; end
      if (do_resp && hold2) begin
        // request held into the acceptance-follow cycle must not re-trigger
        @(negedge clk);
        bus.resp = ~r;
      end
      send_byte(b[0], 1'b0);
      tick($urandom_range(0, 4));
      send_byte(b[1], 1'b0);
      tick($urandom_range(0, 4));
      send_byte(b[2], coinc);
      exp_ovr = coinc ? 1'b0 : (exp_ovr | exp_rdy);
      exp_rdy = 1'b1;
      n_tests++; if (bus.cmd !== exp_cmd) begin n_fail++; $display("FAIL rand_cmd[%0d]: got %h required %h", i, bus.cmd, exp_cmd); end
      n_tests++; if ({bus.cmd_rdy, bus.cmd_ovr} !== {exp_rdy, exp_ovr}) begin n_fail++; $display("FAIL rand_flags[%0d]: rdy,ovr=%b%b required %b%b", i, bus.cmd_rdy, bus.cmd_ovr, exp_rdy, exp_ovr); end
      n_tests++; if (clr_cnt - c0 !== 3) begin n_fail++; $display("FAIL rand_clr_pulses[%0d]: got %0d required 3", i, clr_cnt - c0); end
      if (do_resp) begin
        n_tests++; if ({bus.tx_data, bus.resp_busy} !== {r, 1'b1}) begin n_fail++; $display("FAIL rand_resp[%0d]: tx_data,busy=%h,%b required %h,1", i, bus.tx_data, bus.resp_busy, r); end
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        n_tests++; if (bus.resp_busy !== 1'b0) begin n_fail++; $display("FAIL rand_resp_done[%0d]: busy=%b required 0", i, bus.resp_busy); end
      end
      tick(1);
      n_tests++; if (trmt_cnt - t0 !== (do_resp ? 1 : 0)) begin n_fail++; $display("FAIL rand_trmt[%0d]: got %0d pulses required %0d", i, trmt_cnt - t0, do_resp ? 1 : 0); end
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr_cmd();
        exp_rdy = 1'b0; exp_ovr = 1'b0;
      end
    end
  endtask

  initial begin
    bus.rdy = 1'b0; bus.rx_data = 8'h0; bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0; bus.resp = 8'h0; bus.tx_done = 1'b0;
    test_reset();
    test_basic_cmd();
    test_overrun();
    test_resp();
    test_timeout();
    test_reset_mid();
    test_coincident_clr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500 us, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_proc.md
# uart_cmd_proc

Command framer between the UART receive/transmit pair and the design's control logic. Collects three consecutive received bytes (opcode, data high, data low) into a 24-bit command and presents it with a sticky ready flag. Also drives the transmitter to return a single response byte per request. All bytes enter through the UART `rdy`/`rx_data`/`clr_rdy` handshake and leave through `trmt`/`tx_data`/`tx_done`.

## Interface
- `TIMEOUT_CYC`, 22'd2_604_166 (~50 ms at 50 MHz): inter-byte timeout in clk cycles; used only with the timeout macro.
- `TO_W`, 22: width of the timeout counter; must satisfy `TIMEOUT_CYC < 2**TO_W`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  UART byte-available, level; stays high until cleared.
- `rx_data`  in  8  received byte; valid while `rdy`=1.
- `clr_rdy`  out  1  one-cycle pulse that consumes the current byte.
- `cmd`  out  24  {opcode, data[15:8], data[7:0]}.
- `cmd_rdy`  out  1  sticky; high while `cmd` holds an unconsumed command.
- `clr_cmd_rdy`  in  1  consumer acknowledge; clears `cmd_rdy` and `cmd_ovr`.
- `cmd_ovr`  out  1  sticky; a new command overwrote an unconsumed one.
- `frame_err`  out  1  one-cycle pulse on inter-byte timeout.
- `send_resp`  in  1  request to transmit `resp`.
- `resp`  in  8  response byte; sampled in the cycle `send_resp`=1.
- `trmt`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  8  registered response byte; held until the next accepted request.
- `tx_done`  in  1  transmitter completion; only its rising edge is used.
- `resp_busy`  out  1  high from the accepted request until completion.

## Operation
- Reset value of every output: 0 (`cmd`=24'h0, `tx_data`=8'h0).
- **RX FSM**, states `BYTE_HI` (reset state), `BYTE_MID`, `BYTE_LO`.
  - Capture condition: `rdy && !clr_rdy`. On capture, the byte is latched and `clr_rdy` is driven to 1 in the next cycle only.
  - `BYTE_HI` → `BYTE_MID`: byte goes to `cmd[23:16]`.
  - `BYTE_MID` → `BYTE_LO`: byte goes to `cmd[15:8]`.
  - `BYTE_LO` → `BYTE_HI`: byte goes to `cmd[7:0]`; `cmd_rdy` is set.
  - `cmd[23:8]` use shadow registers. The visible `cmd` updates atomically on third-byte capture; it never shows a partial command.
- Overrun: third-byte capture while `cmd_rdy`=1 overwrites `cmd` and sets `cmd_ovr`.
- `clr_cmd_rdy` in the same cycle as a third-byte capture: the set wins. Result is `cmd_rdy`=1 and `cmd_ovr`=0.
- **TX FSM**, states `IDLE`, `XMIT`.
  - `IDLE` with `send_resp`=1: latch `resp` into `tx_data`, pulse `trmt` next cycle, assert `resp_busy` next cycle, go to `XMIT`.
  - `XMIT`: on `tx_done` rising edge (registered previous value vs current), clear `resp_busy` next cycle and go to `IDLE`.
  - `send_resp` while `resp_busy`=1, or in the acceptance cycle itself, is ignored (dropped, not queued).
- The RX and TX FSMs are independent. Simultaneous byte capture and response request are both serviced.

## Timing
- Byte capture latency: `clr_rdy` high exactly one cycle, in cycle n+1 after capture cycle n.
- `rdy` is expected low by cycle n+2. It is ignored in n+1 by the `!clr_rdy` gating.
- `cmd`/`cmd_rdy` valid in cycle n+1 after the third capture.
- `cmd_rdy` clears in the cycle after `clr_cmd_rdy`.
- `trmt` and `tx_data` are valid together, one cycle after `send_resp`.
- Minimum request-to-request spacing: completion plus 1 cycle.
- Mid-operation `rst_n` low: both FSMs go immediately to their reset states. Partial bytes are discarded. `trmt` drops even if the transmitter is mid-frame.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - An idle counter runs in `BYTE_MID`/`BYTE_LO` and clears on each capture.
  - Reaching `TIMEOUT_CYC-1` returns the FSM to `BYTE_HI`, discards the partial bytes, and pulses `frame_err` for one cycle.
  - Capture in the same cycle as expiry: the capture wins and no error is raised.
- Undefined: no counter is built, `frame_err` is tied 0, and partial commands wait indefinitely.

## Structure
- Package `uart_cmd_pkg` holds:
  - `rx_state_t` and `tx_state_t` enums.
  - `CMD_W`=24 and `BYTE_W`=8.
  - Default `TIMEOUT_CYC`.
- Sub-module `uart_resp_ctrl` holds the TX FSM, `tx_done` edge detection, and the `tx_data` register. The top holds the RX FSM, timeout counter and command registers.

## Test plan
- Bytes 0xA5, 0x12, 0x34 with `rdy` held until `clr_rdy` → `cmd`=24'hA51234, `cmd_rdy`=1, exactly three `clr_rdy` pulses.
- Second command 0x01, 0x00, 0x02 without `clr_cmd_rdy` → `cmd`=24'h010002, `cmd_ovr`=1. Then `clr_cmd_rdy` → both flags 0.
- `send_resp` with `resp`=0xC3 → `trmt` one cycle, `tx_data`=0xC3. A second `send_resp`=0x5A while busy → ignored. `tx_done` rise → `resp_busy` low.
- With `UART_CMD_TIMEOUT_EN` and `TIMEOUT_CYC`=100: send 0x11, 0x22, wait 100 cycles → `frame_err` pulse. Then 0x33, 0x44, 0x55 → `cmd`=24'h334455.
- Assert `rst_n`=0 after two bytes → all outputs 0. Next three bytes 0x0A, 0x0B, 0x0C → `cmd`=24'h0A0B0C.
- Third-byte capture coincident with `clr_cmd_rdy` → `cmd_rdy` stays 1, `cmd_ovr`=0.
